// File: rtl/mips_mem_responder_if.sv
// Data-side bus between the single-cycle MIPS core and its memory responder.
// It also carries the valid/ready push port of the input byte FIFO.
// The master side is the core plus the byte producer; the slave side is the responder.
interface mips_mem_responder_if;

    // Core load/store bus
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;

    // Input byte push port
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;

    modport master (
        output mem_wr,
        output mem_addr,
        output mem_writedata,
        input  mem_readdata,
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  mem_wr,
        input  mem_addr,
        input  mem_writedata,
        output mem_readdata,
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/mips_mem_responder.sv
// Data-side memory responder for the single-cycle MIPS core.
// Loads are answered combinationally in the same cycle. Stores commit on the next rising edge.
// The address space has two targets:
//   - a word-addressed data RAM at DMEM_BASE
//   - a 16-byte I/O page at IO_BASE, which holds:
//       +0x0 FIFO_DATA : head of the input byte FIFO; a store pops one byte
//       +0x4 FIFO_STAT : {count, full, empty}; storing bit0=1 flushes the FIFO
//       +0x8 LED       : 16-bit LED register
//       +0xC CYCLE     : free-running cycle counter; a store loads it
// Reads never change state. Only mem_wr and the push handshake modify anything.
module mips_mem_responder #(
    parameter int unsigned DMEM_WORDS = 64,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] DMEM_BASE  = 32'h1001_0000,
    parameter logic [31:0] IO_BASE    = 32'h1002_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    mips_mem_responder_if.slave  bus
);

    // ------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------
    localparam int unsigned AW = $clog2(DMEM_WORDS);   // RAM index width
    localparam int unsigned PW = $clog2(FIFO_DEPTH);   // FIFO pointer width
    localparam int unsigned CW = PW + 1;               // FIFO count width, holds 0..FIFO_DEPTH

    localparam logic [29:0]   RAM_WORDS  = 30'(DMEM_WORDS);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    // Register slots of the I/O page, selected by mem_addr[3:2]
    typedef enum logic [1:0] {
        IO_FIFO_DATA = 2'd0,
        IO_FIFO_STAT = 2'd1,
        IO_LED       = 2'd2,
        IO_CYCLE     = 2'd3
    } io_reg_e;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [31:0]   r_dmem     [DMEM_WORDS];
    logic [7:0]    r_fifo_mem [FIFO_DEPTH];

    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [15:0]   r_led;
    logic [31:0]   r_cycle;

    // ------------------------------------------------------------------
    // Address decode (byte offset bits [1:0] are ignored throughout)
    // ------------------------------------------------------------------
    logic [29:0]   w_ram_word_off;
    logic          w_ram_hit;
    logic [AW-1:0] w_ram_idx;
    logic          w_io_hit;
    io_reg_e       w_io_reg;

    // Word offset from the RAM base. Addresses below the base wrap to a huge
    // offset, so a single unsigned compare covers both ends of the window.
    assign w_ram_word_off = bus.mem_addr[31:2] - DMEM_BASE[31:2];
    assign w_ram_hit      = (w_ram_word_off < RAM_WORDS);
    assign w_ram_idx      = w_ram_word_off[AW-1:0];

    // The I/O page is one aligned 16-byte block.
    assign w_io_hit = (bus.mem_addr[31:4] == IO_BASE[31:4]);
    assign w_io_reg = io_reg_e'(bus.mem_addr[3:2]);

    // ------------------------------------------------------------------
    // Store strobes per target
    // ------------------------------------------------------------------
    logic w_wr_ram;
    logic w_wr_fifo_data;
    logic w_wr_fifo_stat;
    logic w_wr_led;
    logic w_wr_cycle;

    assign w_wr_ram       = bus.mem_wr && w_ram_hit;
    assign w_wr_fifo_data = bus.mem_wr && w_io_hit && (w_io_reg == IO_FIFO_DATA);
    assign w_wr_fifo_stat = bus.mem_wr && w_io_hit && (w_io_reg == IO_FIFO_STAT);
    assign w_wr_led       = bus.mem_wr && w_io_hit && (w_io_reg == IO_LED);
    assign w_wr_cycle     = bus.mem_wr && w_io_hit && (w_io_reg == IO_CYCLE);

    // ------------------------------------------------------------------
    // FIFO status and events
    // ------------------------------------------------------------------
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_flush;

    assign w_full  = (r_count == FULL_COUNT);
    assign w_empty = (r_count == '0);

    // A push completes whenever the handshake does. A flush in the same cycle
    // still discards the byte, because the flush clears the pointers below.
    assign w_push  = bus.in_valid && !w_full;
    // Popping an empty FIFO is a no-op. This matters when a push and a pop
    // arrive together on an empty FIFO.
    assign w_pop   = w_wr_fifo_data && !w_empty;
    assign w_flush = w_wr_fifo_stat && bus.mem_writedata[0];

    assign bus.in_ready = !w_full;

    // ------------------------------------------------------------------
    // Data RAM: full-word stores; loads see the old word until the edge
    // ------------------------------------------------------------------
    // Write the addressed RAM word on a store; contents survive reset
    // NOTE: large storage arrays get no reset branch, so they map onto plain RAM
    // rather than thousands of resettable flops.
    always_ff @(posedge clk) begin
        if (w_wr_ram) begin
            r_dmem[w_ram_idx] <= bus.mem_writedata;
        end
    end

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    // Capture the pushed byte at the write pointer (storage only, no reset)
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= bus.in_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush has priority over push/pop
    // NOTE: clocked state uses non-blocking (<=) assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers wrap naturally because FIFO_DEPTH is a power of two.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // A simultaneous push and pop leaves the count unchanged.
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // LED register
    // ------------------------------------------------------------------
    // Latch the low half-word of a store to the LED slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_led <= '0;
        end else if (w_wr_led) begin
            r_led <= bus.mem_writedata[15:0];
        end
    end

    // ------------------------------------------------------------------
    // Cycle counter
    // ------------------------------------------------------------------
    // Count every cycle; a store replaces the value for exactly one edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle <= '0;
        end else if (w_wr_cycle) begin
            r_cycle <= bus.mem_writedata;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Combinational read mux
    // ------------------------------------------------------------------
    logic [7:0]  w_count8;
    logic [31:0] w_rdata;

    // The status word has an 8-bit count field. With a 256-deep FIFO a full
    // FIFO shows a count of 0 here; the full flag disambiguates.
    assign w_count8 = 8'(r_count);

    // Select read data from RAM or the I/O page; unmapped addresses read zero
    always_comb begin
        // NOTE: the default assignment first keeps this block purely
        // combinational; an uncovered path would otherwise infer a latch.
        w_rdata = '0;
        if (w_ram_hit) begin
            w_rdata = r_dmem[w_ram_idx];
        end else if (w_io_hit) begin
            case (w_io_reg)
                IO_FIFO_DATA: begin
                    if (!w_empty) begin
                        w_rdata = {24'h0, r_fifo_mem[r_rd_ptr]};
                    end
                end
                IO_FIFO_STAT: w_rdata = {16'h0, w_count8, 6'h0, w_full, w_empty};
                IO_LED:       w_rdata = {16'h0, r_led};
                IO_CYCLE:     w_rdata = r_cycle;
                default:      w_rdata = '0;
            endcase
        end
    end

    assign bus.mem_readdata = w_rdata;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed testbench for mips_mem_responder.
// Stimulus changes 1 ns after each rising edge. The combinational read path is
// sampled a further 1 ns later, well clear of the next edge.
module tb_mips_mem_responder;

    localparam logic [31:0] DMEM = 32'h1001_0000;
    localparam logic [31:0] IO   = 32'h1002_0000;
    localparam logic [31:0] A_FDATA = IO + 32'h0;
    localparam logic [31:0] A_FSTAT = IO + 32'h4;
    localparam logic [31:0] A_LED   = IO + 32'h8;
    localparam logic [31:0] A_CYCLE = IO + 32'hC;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mips_mem_responder_if bus();

    mips_mem_responder #(
        .DMEM_WORDS (64),
        .FIFO_DEPTH (8),
        .DMEM_BASE  (DMEM),
        .IO_BASE    (IO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a load address and compare the combinational read data
    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        bus.mem_wr   = 1'b0;
        bus.mem_addr = addr;
        #1;
        check(tag, bus.mem_readdata, exp);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        bus.mem_wr        = 1'b1;
        bus.mem_addr      = addr;
        bus.mem_writedata = data;
        step();
        bus.mem_wr = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic pop();
        bus_write(A_FDATA, 32'h0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset             = 1'b1;
        bus.mem_wr        = 1'b0;
        bus.mem_addr      = 32'h0;
        bus.mem_writedata = 32'h0;
        bus.in_valid      = 1'b0;
        bus.in_data       = 8'h0;

        // ---------------- reset state ----------------
        step();
        step();
        read_check("rst_stat", A_FSTAT, 32'h0000_0001);
        read_check("rst_led",  A_LED,   32'h0000_0000);
        check("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
        reset = 1'b0;
        bus.mem_addr = A_CYCLE;
        step();
        step();
        step();
        read_check("cycle_after_3", A_CYCLE, 32'd3);

        // ---------------- data RAM ----------------
        bus_write(DMEM + 32'h10, 32'hDEAD_BEEF);
        read_check("ram_rd",         DMEM + 32'h10, 32'hDEAD_BEEF);
        read_check("ram_rd_unalign", DMEM + 32'h13, 32'hDEAD_BEEF);
        read_check("unmapped",       32'h1003_0000, 32'h0);
        // A load during a store to the same word returns the old word
        bus.mem_wr        = 1'b1;
        bus.mem_addr      = DMEM + 32'h10;
        bus.mem_writedata = 32'h1234_5678;
        #1;
        check("ram_rdw_old", bus.mem_readdata, 32'hDEAD_BEEF);
        step();
        bus.mem_wr = 1'b0;
        read_check("ram_rdw_new", DMEM + 32'h10, 32'h1234_5678);
        // Last word in range, then one word past the end (must not alias word 0)
        bus_write(DMEM + 32'h0,  32'h0000_0000);
        bus_write(DMEM + 32'hFC, 32'hCAFE_F00D);
        bus_write(DMEM + 32'h100, 32'hBAD0_BAD0);
        read_check("ram_last",     DMEM + 32'hFC,  32'hCAFE_F00D);
        read_check("ram_past_end", DMEM + 32'h100, 32'h0);
        read_check("ram_no_alias", DMEM + 32'h0,   32'h0);
        read_check("below_base",   DMEM - 32'h4,   32'h0);

        // ---------------- FIFO basics ----------------
        push(8'h41);
        push(8'h42);
        push(8'h43);
        read_check("stat_3",  A_FSTAT, 32'h0000_0300);
        read_check("head_41", A_FDATA, 32'h0000_0041);
        read_check("head_41_noside", A_FDATA, 32'h0000_0041);
        pop();
        read_check("head_42", A_FDATA, 32'h0000_0042);
        read_check("stat_2",  A_FSTAT, 32'h0000_0200);
        pop();
        pop();
        read_check("empty_data", A_FDATA, 32'h0);
        read_check("empty_stat", A_FSTAT, 32'h0000_0001);
        pop();
        read_check("pop_empty_stat", A_FSTAT, 32'h0000_0001);

        // ---------------- fill to full, reject 9th, drain ----------------
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        check("full_in_ready", {31'h0, bus.in_ready}, 32'h0);
        read_check("full_stat", A_FSTAT, 32'h0000_0802);
        push(8'hEE);
        read_check("full_reject_stat", A_FSTAT, 32'h0000_0802);
        read_check("full_head", A_FDATA, 32'h0000_0010);
        pop();
        check("after_pop_in_ready", {31'h0, bus.in_ready}, 32'h1);
        read_check("after_pop_stat", A_FSTAT, 32'h0000_0700);
        for (int i = 1; i < 8; i++) begin
            read_check($sformatf("drain1_%0d", i), A_FDATA, 32'h10 + 32'(i));
            pop();
        end
        read_check("drain1_stat", A_FSTAT, 32'h0000_0001);

        // Second fill/drain wraps the pointers
        for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
        read_check("full2_stat", A_FSTAT, 32'h0000_0802);
        for (int i = 0; i < 8; i++) begin
            read_check($sformatf("drain2_%0d", i), A_FDATA, 32'h20 + 32'(i));
            pop();
        end
        read_check("drain2_stat", A_FSTAT, 32'h0000_0001);

        // ---------------- simultaneous events ----------------
        // Push + pop on empty: the push wins
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        bus_write(A_FDATA, 32'hFFFF_FFFF);
        bus.in_valid = 1'b0;
        read_check("pp_empty_stat", A_FSTAT, 32'h0000_0100);
        read_check("pp_empty_data", A_FDATA, 32'h0000_0055);
        // Push + pop on non-empty: the count holds and the head advances
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h66;
        bus_write(A_FDATA, 32'h0);
        bus.in_valid = 1'b0;
        read_check("pp_ne_stat", A_FSTAT, 32'h0000_0100);
        read_check("pp_ne_data", A_FDATA, 32'h0000_0066);
        // STAT write with bit0=0 is ignored
        bus_write(A_FSTAT, 32'h0000_0002);
        read_check("stat_wr0_ign", A_FSTAT, 32'h0000_0100);
        // Flush + push: the flush wins
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h77;
        bus_write(A_FSTAT, 32'h0000_0001);
        bus.in_valid = 1'b0;
        read_check("flush_push_stat", A_FSTAT, 32'h0000_0001);
        read_check("flush_push_data", A_FDATA, 32'h0);

        // ---------------- LED ----------------
        bus_write(A_LED, 32'hABCD_1234);
        read_check("led", A_LED, 32'h0000_1234);

        // ---------------- CYCLE load and wrap ----------------
        bus_write(A_CYCLE, 32'hFFFF_FFFE);
        read_check("cycle_load", A_CYCLE, 32'hFFFF_FFFE);
        step();
        read_check("cycle_max", A_CYCLE, 32'hFFFF_FFFF);
        step();
        read_check("cycle_wrap", A_CYCLE, 32'h0000_0000);

        // ---------------- reset mid-fill ----------------
        push(8'h01);
        push(8'h02);
        read_check("prefill_stat", A_FSTAT, 32'h0000_0200);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h03;
        reset = 1'b1;
        read_check("midrst_stat", A_FSTAT, 32'h0000_0001);
        read_check("midrst_led",  A_LED,   32'h0000_0000);
        check("midrst_in_ready", {31'h0, bus.in_ready}, 32'h1);
        step();
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        read_check("postrst_stat", A_FSTAT, 32'h0000_0001);
        read_check("postrst_data", A_FDATA, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_mem_responder.md
Name: mips_mem_responder

Overview:
Data-side responder for the single-cycle MIPS core. It accepts the core's mem_wr/mem_addr/mem_writedata bus and returns mem_readdata in the same cycle. Address decode selects one of two targets: a word-addressed data RAM, or a small memory-mapped I/O page. The I/O page holds an input byte FIFO with a valid/ready push port, a LED register and a free-running cycle counter.

Parameters:
DMEM_WORDS, 64, data RAM depth in 32-bit words; power of 2, 4..1024
FIFO_DEPTH, 8, input FIFO depth in bytes; power of 2, 2..256
DMEM_BASE, 32'h1001_0000, byte base address of data RAM
IO_BASE, 32'h1002_0000, byte base address of I/O page

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state except RAM contents
mem_wr  in  1  store strobe from core; write takes effect at the next rising edge
mem_addr  in  32  byte address from core; bits [1:0] ignored
mem_writedata  in  32  store data from core
mem_readdata  out  32  combinational read data for mem_addr
in_valid  in  1  producer has a byte on in_data
in_data  in  8  input byte
in_ready  out  1  FIFO can accept; equals !full

Behaviour:
- Address map (word-aligned, addr[1:0] ignored):
  - RAM: DMEM_BASE .. DMEM_BASE+4*DMEM_WORDS-1. Index = (mem_addr-DMEM_BASE)>>2.
  - FIFO_DATA: IO_BASE+0x0
  - FIFO_STAT: IO_BASE+0x4
  - LED: IO_BASE+0x8
  - CYCLE: IO_BASE+0xC
  - Any other address reads 32'h0. Writes to it are ignored.
- Reads: purely combinational from mem_addr and current state, with zero-cycle latency. Reads have no side effects.
- RAM: write of full 32-bit word on the edge when mem_wr is high. Contents are not cleared by reset. Read-during-write returns the old word in that cycle.
- FIFO_DATA read:
  - Non-empty: {24'h0, head byte}.
  - Empty: 32'h0.
- FIFO_DATA write with any data pops one entry if non-empty. On an empty FIFO it is a no-op.
- FIFO_STAT read: {16'h0, count[7:0], 6'h0, full, empty}. count ranges 0..FIFO_DEPTH.
- FIFO_STAT write with writedata[0]=1 flushes the FIFO: count, rd_ptr and wr_ptr go to 0. Writes with writedata[0]=0 are ignored.
- Push: occurs on an edge where in_valid && in_ready. in_data is stored at wr_ptr, then wr_ptr advances, wrapping modulo FIFO_DEPTH.
- Simultaneous events in one cycle:
  - Push + pop on a non-empty, non-full FIFO: both happen and count is unchanged.
  - Push + pop on an empty FIFO: the pop is ignored and the push happens, so count goes 0->1.
  - Full FIFO: in_ready=0, no push; a pop lowers count and in_ready rises the next cycle.
  - Flush + push: flush wins and the pushed byte is discarded, although the handshake completed. Count becomes 0.
- LED write: led_reg <= writedata[15:0]. LED read returns {16'h0, led_reg}. led_reg is internal and visible only via the bus.
- CYCLE: increments by 1 every cycle, wrapping 32'hFFFF_FFFF -> 0.
  - A CYCLE write loads writedata. The read in the next cycle returns writedata, and increments resume after that.
- Reset (asynchronous):
  - count, rd_ptr, wr_ptr, led_reg and cycle all go to 0.
  - in_ready=1.
  - mem_readdata reflects the reset state immediately, e.g. FIFO_STAT reads 32'h1.
  - Reset mid-push: the byte is lost.
- Only the port named mem_wr causes writes. There is no read strobe, so no read may change state.

Test Plan:
- Reset, then read FIFO_STAT -> 32'h0000_0001; read LED -> 0; in_ready=1; read CYCLE 3 cycles after reset release -> 3.
- Write 32'hDEAD_BEEF to DMEM_BASE+0x10, then read DMEM_BASE+0x10 -> 32'hDEAD_BEEF; read DMEM_BASE+0x13 -> same; read 32'h1003_0000 -> 0.
- Push 0x41, 0x42, 0x43 -> FIFO_STAT = 32'h0000_0300; FIFO_DATA reads 0x41; write FIFO_DATA -> reads 0x42, STAT count 2.
- Push 8 bytes (DEPTH=8) -> in_ready=0, STAT=32'h0000_0802; a 9th in_valid is not accepted; pop once -> in_ready=1 next cycle, count 7. Fill/drain twice to exercise pointer wrap; order is preserved.
- Empty FIFO with push 0x55 and FIFO_DATA write in the same cycle -> count 1, FIFO_DATA reads 0x55. Flush write with a simultaneous push -> STAT=32'h1.
- Write CYCLE=32'hFFFF_FFFE -> reads FFFF_FFFE, FFFF_FFFF, 0000_0000 on successive cycles. Assert reset mid-fill of 4 bytes -> STAT=1 immediately, LED=0.
